// File: rtl/victim_cache.sv
// rtl/victim_cache.sv - four-entry fully associative write-back victim cache between L2 and physical memory
module victim_cache (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    input  logic         mem_write,
    input  logic         mem_read,
    output logic         mem_resp,
    output logic [127:0] mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    typedef enum logic [1:0] {S_IDLE, S_RESP, S_FETCH, S_WB} state_t;

    state_t       r_state;
    state_t       w_next_state;

    logic         r_valid [4];
    logic         r_dirty [4];
    logic [11:0]  r_tag   [4];
    logic [127:0] r_data  [4];
    logic [1:0]   r_age   [4];
    logic [127:0] r_buf;
    logic [1:0]   r_way;

    logic [11:0]  w_tag;
    logic         w_unused_addr;
    logic         w_hit;
    logic [1:0]   w_hit_way;
    logic         w_free;
    logic [1:0]   w_free_way;
    logic [1:0]   w_lru_way;
    logic [1:0]   w_repl_way;

    logic         w_upd_en;
    logic [1:0]   w_upd_way;
    logic         w_touch_en;
    logic [1:0]   w_touch_way;
    logic         w_buf_en;
    logic [127:0] w_buf_data;
    logic         w_way_en;

    assign w_tag         = mem_address[15:4];
    assign w_unused_addr = ^mem_address[3:0];

    // Downward scan so the lowest-index invalid entry wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = 2'd0;
        w_free     = 1'b0;
        w_free_way = 2'd0;
        w_lru_way  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = 2'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_way = 2'(i);
            end
            if (r_age[i] == 2'd3) begin
                w_lru_way = 2'(i);
            end
        end
    end

    assign w_repl_way = w_free ? w_free_way : w_lru_way;

    always_comb begin
        w_next_state = r_state;
        w_upd_en     = 1'b0;
        w_upd_way    = w_hit_way;
        w_touch_en   = 1'b0;
        w_touch_way  = w_hit_way;
        w_buf_en     = 1'b0;
        w_buf_data   = r_data[w_hit_way];
        w_way_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_write) begin
                    if (w_hit) begin
                        w_upd_en     = 1'b1;
                        w_touch_en   = 1'b1;
                        w_next_state = S_RESP;
                    end else if (w_free || !r_dirty[w_lru_way]) begin
                        // Clean victims are simply overwritten without a write-back.
                        w_upd_en     = 1'b1;
                        w_upd_way    = w_repl_way;
                        w_touch_en   = 1'b1;
                        w_touch_way  = w_repl_way;
                        w_next_state = S_RESP;
                    end else begin
                        w_way_en     = 1'b1;
                        w_next_state = S_WB;
                    end
                end else if (mem_read) begin
                    if (w_hit) begin
                        w_buf_en     = 1'b1;
                        w_touch_en   = 1'b1;
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (pmem_resp) begin
                    w_buf_en     = 1'b1;
                    w_buf_data   = pmem_rdata;
                    w_next_state = S_RESP;
                end
            end
            S_WB: begin
                if (pmem_resp) begin
                    w_upd_en     = 1'b1;
                    w_upd_way    = r_way;
                    w_touch_en   = 1'b1;
                    w_touch_way  = r_way;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_way   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_valid[i] <= 1'b0;
                r_dirty[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
                r_age[i]   <= 2'(i);
            end
        end else begin
            r_state <= w_next_state;
            if (w_buf_en) begin
                r_buf <= w_buf_data;
            end
            if (w_way_en) begin
                r_way <= w_lru_way;
            end
            for (int i = 0; i < 4; i++) begin
                if (w_upd_en && (w_upd_way == 2'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_dirty[i] <= 1'b1;
                    r_tag[i]   <= w_tag;
                    r_data[i]  <= mem_wdata;
                end
                // Ages stay a permutation: only entries younger than the touched one age.
                if (w_touch_en) begin
                    if (w_touch_way == 2'(i)) begin
                        r_age[i] <= 2'd0;
                    end else if (r_age[i] < r_age[w_touch_way]) begin
                        r_age[i] <= r_age[i] + 2'd1;
                    end
                end
            end
        end
    end

    assign mem_resp     = (r_state == S_RESP);
    assign mem_rdata    = r_buf;
    assign pmem_read    = (r_state == S_FETCH);
    assign pmem_write   = (r_state == S_WB);
    assign pmem_address = (r_state == S_FETCH) ? {w_tag, 4'b0000} :
                          (r_state == S_WB)    ? {r_tag[r_way], 4'b0000} : 16'h0000;
    assign pmem_wdata   = (r_state == S_WB) ? r_data[r_way] : '0;

endmodule

// File: tb/tb_victim_cache.sv
// tb/tb_victim_cache.sv - directed scoreboard bench for victim_cache
module tb_victim_cache;
    logic         clk;
    logic         rst;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_write;
    logic         mem_read;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           lat;
        bit           chk_data;
        logic [127:0] data;
    } exp_t;
    exp_t sb[$];

    localparam logic [127:0] DA = {16{8'hAA}};
    localparam logic [127:0] D5 = {16{8'h55}};
    localparam logic [127:0] D0 = {8{16'hD000}};
    localparam logic [127:0] D1 = {8{16'hD111}};
    localparam logic [127:0] D2 = {8{16'hD222}};
    localparam logic [127:0] D3 = {8{16'hD333}};
    localparam logic [127:0] D4 = {8{16'hD444}};
    localparam logic [127:0] DP = {8{16'hBEEF}};
    localparam logic [127:0] DX = {8{16'h1111}};
    localparam logic [127:0] DY = {8{16'h2222}};
    localparam logic [127:0] DF = {8{16'hF00D}};

    victim_cache dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one L2 request, plays physical memory, and checks the response against the scoreboard.
    task automatic access(input string tag, input bit wr, input logic [15:0] addr,
                          input logic [127:0] wd, input int pdelay,
                          input bit exp_prd, input bit exp_pwr,
                          input logic [15:0] exp_paddr, input logic [127:0] exp_pwdata,
                          input logic [127:0] prdata, input logic [127:0] exp_rdata);
        exp_t e;
        int cyc, pcnt, lat;
        bit got, saw_rd, saw_wr;
        logic [127:0] rd;
        e.lat = (exp_prd || exp_pwr) ? pdelay + 1 : 1;
        e.chk_data = !wr;
        e.data = exp_rdata;
        sb.push_back(e);
        @(negedge clk);
        mem_address = addr;
        mem_wdata = wd;
        mem_write = wr;
        mem_read = !wr;
        cyc = 0; pcnt = 0; lat = 0; got = 0; saw_rd = 0; saw_wr = 0; rd = '0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            pmem_resp = 1'b0;
            if (mem_resp) begin
                got = 1;
                lat = cyc;
                rd = mem_rdata;
            end else if (pmem_read || pmem_write) begin
                saw_rd |= pmem_read;
                saw_wr |= pmem_write;
                check({tag, "_paddr"}, 128'(pmem_address), 128'(exp_paddr));
                if (pmem_write) check({tag, "_pwdata"}, pmem_wdata, exp_pwdata);
                pcnt++;
                if (pcnt == pdelay) begin
                    pmem_resp = 1'b1;
                    pmem_rdata = prdata;
                end
            end
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        e = sb.pop_front();
        check({tag, "_resp"}, 128'(got), 128'(1));
        check({tag, "_lat"}, 128'(lat), 128'(e.lat));
        if (e.chk_data) check({tag, "_rdata"}, rd, e.data);
        check({tag, "_pmem_rd"}, 128'(saw_rd), 128'(exp_prd));
        check({tag, "_pmem_wr"}, 128'(saw_wr), 128'(exp_pwr));
        @(negedge clk);
        check({tag, "_resp_one_cycle"}, 128'(mem_resp), 128'(0));
    endtask

    initial begin
        int resp_seen;
        rst = 1'b1;
        mem_address = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read = 1'b0;
        pmem_rdata = '0;
        pmem_resp = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_resp", 128'(mem_resp), 128'(0));
        check("rst_pmem_read", 128'(pmem_read), 128'(0));
        check("rst_pmem_write", 128'(pmem_write), 128'(0));
        check("rst_pmem_address", 128'(pmem_address), 128'(0));
        check("rst_pmem_wdata", pmem_wdata, '0);
        check("rst_mem_rdata", mem_rdata, '0);

        access("wr1230", 1, 16'h1230, DA, 0, 0, 0, 16'h0, '0, '0, '0);
        access("rd1238", 0, 16'h1238, '0, 0, 0, 0, 16'h0, '0, '0, DA);
        access("rd4000_miss", 0, 16'h4000, '0, 3, 1, 0, 16'h4000, '0, D5, D5);
        access("rd4000_again", 0, 16'h4000, '0, 1, 1, 0, 16'h4000, '0, D5, D5);

        do_reset();
        access("wr0000", 1, 16'h0000, D0, 0, 0, 0, 16'h0, '0, '0, '0);
        access("wr0010", 1, 16'h0010, D1, 0, 0, 0, 16'h0, '0, '0, '0);
        access("wr0020", 1, 16'h0020, D2, 0, 0, 0, 16'h0, '0, '0, '0);
        access("wr0030", 1, 16'h0030, D3, 0, 0, 0, 16'h0, '0, '0, '0);
        access("rd0000", 0, 16'h0000, '0, 0, 0, 0, 16'h0, '0, '0, D0);
        access("wr0040_evict", 1, 16'h0040, D4, 2, 0, 1, 16'h0010, D1, '0, '0);
        access("rd0040", 0, 16'h0040, '0, 0, 0, 0, 16'h0, '0, '0, D4);
        access("rd0000_b", 0, 16'h0000, '0, 0, 0, 0, 16'h0, '0, '0, D0);
        access("rd0010_miss", 0, 16'h0010, '0, 2, 1, 0, 16'h0010, '0, DP, DP);

        do_reset();
        access("wr0010_x", 1, 16'h0010, DX, 0, 0, 0, 16'h0, '0, '0, '0);
        access("wr0010_y", 1, 16'h0010, DY, 0, 0, 0, 16'h0, '0, '0, '0);
        access("wr0100", 1, 16'h0100, D1, 0, 0, 0, 16'h0, '0, '0, '0);
        access("wr0200", 1, 16'h0200, D2, 0, 0, 0, 16'h0, '0, '0, '0);
        access("wr0300", 1, 16'h0300, D3, 0, 0, 0, 16'h0, '0, '0, '0);
        access("rd0010_y", 0, 16'h0010, '0, 0, 0, 0, 16'h0, '0, '0, DY);

        do_reset();
        access("wr1230_b", 1, 16'h1230, DA, 0, 0, 0, 16'h0, '0, '0, '0);
        @(negedge clk);
        mem_address = 16'h7000;
        mem_read = 1'b1;
        repeat (2) @(negedge clk);
        check("fetch_pmem_read", 128'(pmem_read), 128'(1));
        check("fetch_paddr", 128'(pmem_address), 128'(16'h7000));
        rst = 1'b1;
        @(negedge clk);
        check("abort_pmem_read", 128'(pmem_read), 128'(0));
        check("abort_mem_resp", 128'(mem_resp), 128'(0));
        rst = 1'b0;
        mem_read = 1'b0;
        resp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            resp_seen += int'(mem_resp);
        end
        check("abort_no_resp", 128'(resp_seen), 128'(0));
        access("rd1230_after_rst", 0, 16'h1230, '0, 2, 1, 0, 16'h1230, '0, DF, DF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
